// File: rtl/mem_stage.sv
// MEM stage: EX/MEM pipeline register plus a word-addressed data memory
// with synchronous write, combinational read and a combinational debug port.
module mem_stage #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_wreg,
  input  logic              ex_m2reg,
  input  logic              ex_wmem,
  input  logic [31:0]       ex_aluR,
  input  logic [31:0]       ex_storeData,
  input  logic [4:0]        ex_destR,
  input  logic [3:0]        EX_ins_type,
  input  logic [3:0]        EX_ins_number,
  output logic              mem_wreg,
  output logic              mem_m2reg,
  output logic [4:0]        mem_destR,
  output logic [31:0]       mem_aluR,
  output logic [31:0]       mem_mdata,
  output logic [3:0]        MEM_ins_type,
  output logic [3:0]        MEM_ins_number,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [31:0]       dbg_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic              wreg_reg;
  logic              m2reg_reg;
  logic              wmem_reg;
  logic [31:0]       alur_reg;
  logic [31:0]       sdata_reg;
  logic [4:0]        destr_reg;
  logic [3:0]        type_reg;
  logic [3:0]        num_reg;
  logic [ADDR_W-1:0] idx;

  // Array starts at zero in simulation; reset deliberately leaves it alone.
  logic [31:0] dmem [DEPTH] = '{default: '0};

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wreg_reg  <= 1'b0;
      m2reg_reg <= 1'b0;
      wmem_reg  <= 1'b0;
      alur_reg  <= '0;
      sdata_reg <= '0;
      destr_reg <= '0;
      type_reg  <= '0;
      num_reg   <= '0;
    end else if (!stall) begin
      wreg_reg  <= ex_wreg;
      m2reg_reg <= ex_m2reg;
      wmem_reg  <= ex_wmem;
      alur_reg  <= ex_aluR;
      sdata_reg <= ex_storeData;
      destr_reg <= ex_destR;
      type_reg  <= EX_ins_type;
      num_reg   <= EX_ins_number;
    end
  end

  // Byte offset and high address bits are dropped: accesses wrap per word.
  assign idx = alur_reg[ADDR_W+1:2];

  // Flush only bubbles the incoming slot, so the store already in MEM still commits.
  always_ff @(posedge clk) begin
    if (wmem_reg && !stall && !rst) begin
      dmem[idx] <= sdata_reg;
    end
  end

  assign mem_wreg       = wreg_reg;
  assign mem_m2reg      = m2reg_reg;
  assign mem_destR      = destr_reg;
  assign mem_aluR       = alur_reg;
  assign MEM_ins_type   = type_reg;
  assign MEM_ins_number = num_reg;
  assign mem_mdata      = dmem[idx];
  assign dbg_data       = dmem[dbg_addr];

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios followed by random traffic, all
// checked against a transaction-level model of the MEM slot and memory.
module tb_mem_stage;

  localparam int ADDR_W = 6;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic              clk = 1'b0;
  logic              rst, stall, flush;
  logic              ex_wreg, ex_m2reg, ex_wmem;
  logic [31:0]       ex_aluR, ex_storeData;
  logic [4:0]        ex_destR;
  logic [3:0]        EX_ins_type, EX_ins_number;
  logic              mem_wreg, mem_m2reg;
  logic [4:0]        mem_destR;
  logic [31:0]       mem_aluR, mem_mdata;
  logic [3:0]        MEM_ins_type, MEM_ins_number;
  logic [ADDR_W-1:0] dbg_addr;
  logic [31:0]       dbg_data;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        wreg;
    logic        m2reg;
    logic        wmem;
    logic [31:0] alu;
    logic [31:0] sd;
    logic [4:0]  dst;
    logic [3:0]  ty;
    logic [3:0]  num;
  } ins_t;

  ins_t        m_ins;
  logic [31:0] m_mem [DEPTH];
  int          cyc = 0;

  mem_stage #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_wmem(ex_wmem),
    .ex_aluR(ex_aluR), .ex_storeData(ex_storeData), .ex_destR(ex_destR),
    .EX_ins_type(EX_ins_type), .EX_ins_number(EX_ins_number),
    .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_destR(mem_destR),
    .mem_aluR(mem_aluR), .mem_mdata(mem_mdata),
    .MEM_ins_type(MEM_ins_type), .MEM_ins_number(MEM_ins_number),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic set_ex(input logic wr, input logic m2, input logic wm, input logic [31:0] alu,
                        input logic [31:0] sd, input logic [4:0] dst, input logic [3:0] num);
    ex_wreg = wr; ex_m2reg = m2; ex_wmem = wm; ex_aluR = alu;
    ex_storeData = sd; ex_destR = dst; EX_ins_type = 4'(num + 4'd3); EX_ins_number = num;
  endtask

  // One clock: retire the store in MEM, move the EX instruction in, check.
  task automatic tick();
    ins_t nxt;
    if (m_ins.wmem && !stall && !rst) m_mem[m_ins.alu[ADDR_W+1:2]] = m_ins.sd;
    if (rst || flush) nxt = '0;
    else if (stall)   nxt = m_ins;
    else nxt = '{wreg: ex_wreg, m2reg: ex_m2reg, wmem: ex_wmem, alu: ex_aluR,
                 sd: ex_storeData, dst: ex_destR, ty: EX_ins_type, num: EX_ins_number};
    @(posedge clk);
    #1;
    cyc++;
    m_ins = nxt;
    chk("wreg",   32'(mem_wreg),       32'(m_ins.wreg));
    chk("m2reg",  32'(mem_m2reg),      32'(m_ins.m2reg));
    chk("destR",  32'(mem_destR),      32'(m_ins.dst));
    chk("aluR",   mem_aluR,            m_ins.alu);
    chk("type",   32'(MEM_ins_type),   32'(m_ins.ty));
    chk("number", 32'(MEM_ins_number), 32'(m_ins.num));
    chk("mdata",  mem_mdata,           m_mem[m_ins.alu[ADDR_W+1:2]]);
    chk("dbg",    dbg_data,            m_mem[dbg_addr]);
    $display("cyc=%0d rst=%0b stall=%0b flush=%0b alu=%h mdata=%h dbg[%0d]=%h",
             cyc, rst, stall, flush, mem_aluR, mem_mdata, dbg_addr, dbg_data);
  endtask

  initial begin
    m_ins = '0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    rst = 1'b1; stall = 1'b0; flush = 1'b0; dbg_addr = '0;
    set_ex(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0, 5'd9, 4'h1);

    // Reset holds everything at zero.
    tick(); tick();
    chk("rst_wreg", 32'(mem_wreg), 32'd0);
    chk("rst_dbg0", dbg_data, 32'd0);
    rst = 1'b0;

    // Store followed directly by a load to the same word.
    set_ex(1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 5'd0, 4'h2);
    tick();
    set_ex(1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 5'd5, 4'h3);
    dbg_addr = 6'd4;
    tick();
    chk("lw_mdata", mem_mdata, 32'hDEAD_BEEF);
    chk("lw_destR", 32'(mem_destR), 32'd5);
    chk("lw_dbg4",  dbg_data, 32'hDEAD_BEEF);

    // Stalled store commits only once stall drops.
    set_ex(1'b0, 1'b0, 1'b1, 32'h0000_0008, 32'h1234_5678, 5'd0, 4'h4);
    dbg_addr = 6'd2;
    tick();
    set_ex(1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0, 5'd0, 4'h5);
    stall = 1'b1;
    repeat (3) tick();
    chk("stall_dbg2_old", dbg_data, 32'd0);
    chk("stall_alu_held", mem_aluR, 32'h0000_0008);
    stall = 1'b0;
    tick();
    chk("stall_dbg2_new", dbg_data, 32'h1234_5678);

    // Flush turns the incoming store into a bubble.
    set_ex(1'b1, 1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 5'd7, 4'h7);
    flush = 1'b1;
    dbg_addr = 6'd8;
    tick();
    chk("flush_wreg", 32'(mem_wreg), 32'd0);
    chk("flush_num",  32'(MEM_ins_number), 32'd0);
    flush = 1'b0;
    set_ex(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 4'h8);
    tick();
    chk("flush_nowrite", dbg_data, 32'd0);

    // Address wrap and ignored byte offset.
    set_ex(1'b0, 1'b0, 1'b1, 32'h0000_0103, 32'hA5A5_A5A5, 5'd0, 4'h9);
    dbg_addr = 6'd0;
    tick();
    set_ex(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 4'hA);
    tick();
    chk("wrap_dbg0", dbg_data, 32'hA5A5_A5A5);

    // Reset during a store's MEM cycle blocks the write.
    set_ex(1'b0, 1'b0, 1'b1, 32'h0000_000C, 32'h5555_5555, 5'd0, 4'hB);
    dbg_addr = 6'd3;
    tick();
    rst = 1'b1;
    set_ex(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 4'hC);
    tick();
    chk("rstst_dbg3", dbg_data, 32'd0);
    chk("rstst_alu",  mem_aluR, 32'd0);
    rst = 1'b0;

    // Random traffic; a narrow address pool makes stores and loads collide.
    for (int n = 0; n < 400; n++) begin
      rst   = ($urandom_range(0, 99) < 2);
      stall = ($urandom_range(0, 99) < 20);
      flush = ($urandom_range(0, 99) < 10);
      set_ex(1'($urandom), 1'($urandom), ($urandom_range(0, 99) < 40),
             ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 63)),
             $urandom, 5'($urandom), 4'($urandom));
      dbg_addr = ADDR_W'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
